maestro_ram: RTL

MAESTRO_RAM -- requirements
Module: maestro_ram

---
 rtl/maestro_ram_pkg.sv | 19 +
 rtl/maestro_ram.sv | 135 +++++++++++++
 2 files changed

// File: rtl/maestro_ram_pkg.sv
// Shared constants and FSM encoding for the maestro_ram controller of an
// asynchronous single-port RAM.
package maestro_ram_pkg;

  localparam int unsigned PROF  = 11;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned LEN_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWrite,
    StHold,
    StRead,
    StResp
  } state_e;

endpackage

// File: rtl/maestro_ram.sv
// Command-driven controller for an asynchronous RAM: single-word writes with
// setup/hold framing around a one-cycle EN strobe, and range-limited burst reads.
module maestro_ram
  import maestro_ram_pkg::*;
#(
  parameter int unsigned PROF = maestro_ram_pkg::PROF,
  parameter int unsigned AW   = maestro_ram_pkg::AW,
  parameter int unsigned DW   = maestro_ram_pkg::DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_wr_i,
  input  logic [AW-1:0]    req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [DW-1:0]    req_wdata_i,
  output logic             rd_valid_o,
  output logic [DW-1:0]    rd_data_o,
  output logic             rd_last_o,
  input  logic             rd_ready_i,
  output logic             wr_done_o,
  output logic             err_o,
  output logic [AW-1:0]    direccion_o,
  output logic [DW-1:0]    dato_e_o,
  output logic             en_o,
  input  logic [DW-1:0]    dato_s_i
);

  localparam logic [AW:0] ProfLim = PROF[AW:0];

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             err_q, err_d;
  logic             live_q;

  logic [AW:0] next_addr;
  logic        last_word;
  logic        accept;
  logic        out_of_range;

  // One extra address bit so the PROF limit is visible even at the top of AW.
  assign next_addr    = {1'b0, addr_q} + 1'b1;
  assign last_word    = (cnt_q == LEN_W'(1)) || (next_addr >= ProfLim);
  assign accept       = req_valid_i && req_ready_o;
  assign out_of_range = {1'b0, req_addr_i} >= ProfLim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (out_of_range) begin
            err_d = 1'b1;
          end else begin
            addr_d  = req_addr_i;
            wr_d    = req_wr_i;
            state_d = StSetup;
            if (req_wr_i) begin
              wdata_d = req_wdata_i;
              cnt_d   = '0;
            end else begin
              cnt_d = (req_len_i == '0) ? LEN_W'(1) : req_len_i;
            end
          end
        end
      end
      StSetup: state_d = wr_q ? StWrite : StRead;
      StWrite: state_d = StHold;
      StHold:  state_d = StIdle;
      StRead: begin
        rdata_d = dato_s_i;
        state_d = StResp;
      end
      StResp: begin
        if (rd_ready_i) begin
          if (last_word) begin
            // Words still owed here means the burst ran into PROF.
            err_d   = (cnt_q != LEN_W'(1));
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            addr_d  = next_addr[AW-1:0];
            state_d = StSetup;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready_o = live_q && (state_q == StIdle);
  assign en_o        = (state_q == StWrite);
  assign wr_done_o   = (state_q == StHold);
  assign rd_valid_o  = (state_q == StResp);
  assign rd_last_o   = (state_q == StResp) && last_word;
  assign rd_data_o   = rdata_q;
  assign direccion_o = addr_q;
  assign dato_e_o    = wdata_q;
  assign err_o       = err_q;

endmodule
